// File: rtl/keypad_entry_if.sv
// Scanner result and committed-amount handshake between the keypad entry block and its neighbours.
// The slave view belongs to keypad_entry. The master view belongs to the scanner/consumer side.
interface keypad_entry_if #(
  parameter int VALUE_W = 20
);
  logic               key_valid;
  logic [31:0]        key_row;
  logic [31:0]        key_col;
  logic               scan_start;
  logic [VALUE_W-1:0] amount;
  logic               amount_valid;
  logic               amount_ready;

  modport slave (
    input  key_valid, key_row, key_col, amount_ready,
    output scan_start, amount, amount_valid
  );

  modport master (
    output key_valid, key_row, key_col, amount_ready,
    input  scan_start, amount, amount_valid
  );
endinterface

// File: rtl/keypad_entry.sv
// Debounces 4x3 keypad scanner results into key strobes and accumulates a decimal amount.
// '*' clears the entry. '#' commits the entry over a valid/ready handshake.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RELEASE_CYCLES  = 16,
  parameter int MAX_DIGITS      = 6,
  parameter int VALUE_W         = 20
) (
  input  logic               clock,
  input  logic               resetn,
  keypad_entry_if.slave      bus,
  output logic               key_pulse,
  output logic [3:0]         key_code,
  output logic [VALUE_W-1:0] entry_value,
  output logic [3:0]         digit_count,
  output logic               overflow_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_STABLE, S_RELEASE} db_state_t;
  typedef enum logic       {S_ENTER, S_COMMIT}           en_state_t;

  // Row-major keypad layout; the bottom row carries '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    end
    return code;
  endfunction

  // Out-of-range coordinates are indistinguishable from no key at all.
  logic key_ok;
  assign key_ok = bus.key_valid && (bus.key_row < 32'd4) && (bus.key_col < 32'd3);

  db_state_t        db_state, db_next;
  logic [1:0]       row_q, row_next, col_q, col_next;
  logic [CNT_W-1:0] cnt_q, cnt_next, cnt_inc;
  logic [REL_W-1:0] rel_q, rel_next;
  logic             pulse_next, scan_req;
  logic [3:0]       code_next;

  // NOTE: every variable written below gets a default first, so no path can infer a latch.
  always_comb begin
    db_next    = db_state;
    row_next   = row_q;
    col_next   = col_q;
    cnt_next   = cnt_q;
    rel_next   = rel_q;
    pulse_next = 1'b0;
    code_next  = key_code;
    scan_req   = 1'b1;
    cnt_inc    = cnt_q + CNT_W'(1);
    case (db_state)
      S_IDLE: begin
        if (key_ok) begin
          row_next = bus.key_row[1:0];
          col_next = bus.key_col[1:0];
          cnt_next = CNT_W'(1);
          if (DEBOUNCE_CYCLES <= 1) begin
            pulse_next = 1'b1;
            code_next  = key_map(bus.key_row[1:0], bus.key_col[1:0]);
            rel_next   = '0;
            db_next    = S_RELEASE;
          end else begin
            db_next = S_STABLE;
          end
        end
      end
      S_STABLE: begin
        if (key_ok && bus.key_row[1:0] == row_q && bus.key_col[1:0] == col_q) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            pulse_next = 1'b1;
            code_next  = key_map(row_q, col_q);
            rel_next   = '0;
            db_next    = S_RELEASE;
          end
        end else begin
          db_next = S_IDLE;
        end
      end
      S_RELEASE: begin
        scan_req = 1'b0;
        // Any activity restarts the quiet-run count, so a held key is accepted only once.
        if (key_ok) begin
          rel_next = '0;
        end else if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
          rel_next = '0;
          db_next  = S_IDLE;
        end else begin
          rel_next = rel_q + REL_W'(1);
        end
      end
      default: db_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db_state  <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      key_pulse <= 1'b0;
      key_code  <= '0;
    end else begin
      db_state  <= db_next;
      row_q     <= row_next;
      col_q     <= col_next;
      cnt_q     <= cnt_next;
      rel_q     <= rel_next;
      key_pulse <= pulse_next;
      key_code  <= code_next;
    end
  end

  assign bus.scan_start = scan_req;

  en_state_t          en_state, en_next;
  logic [VALUE_W-1:0] value_next, amount_q, amount_next;
  logic [3:0]         count_next;
  logic               valid_q, valid_next, ovf_next;

  always_comb begin
    en_next     = en_state;
    value_next  = entry_value;
    count_next  = digit_count;
    amount_next = amount_q;
    valid_next  = valid_q;
    ovf_next    = 1'b0;
    case (en_state)
      S_ENTER: begin
        if (key_pulse) begin
          if (key_code <= 4'd9) begin
            if (digit_count < 4'(MAX_DIGITS)) begin
              value_next = (entry_value << 3) + (entry_value << 1) + VALUE_W'(key_code);
              count_next = digit_count + 4'd1;
            end else begin
              ovf_next = 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            value_next = '0;
            count_next = '0;
          end else if (digit_count != 4'd0) begin
            amount_next = entry_value;
            valid_next  = 1'b1;
            en_next     = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        // Keys are still debounced here but the entry is frozen until the amount is taken.
        if (bus.amount_ready) begin
          valid_next = 1'b0;
          value_next = '0;
          count_next = '0;
          en_next    = S_ENTER;
        end
      end
      default: en_next = S_ENTER;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      en_state     <= S_ENTER;
      entry_value  <= '0;
      digit_count  <= '0;
      amount_q     <= '0;
      valid_q      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      en_state     <= en_next;
      entry_value  <= value_next;
      digit_count  <= count_next;
      amount_q     <= amount_next;
      valid_q      <= valid_next;
      overflow_err <= ovf_next;
    end
  end

  assign bus.amount       = amount_q;
  assign bus.amount_valid = valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a key-level reference model is checked every cycle,
// and literal expectations at the end of each scenario pin that model down.
module tb_keypad_entry;

  localparam int DB  = 4;
  localparam int REL = 3;
  localparam int VW  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_pulse, overflow_err;
  logic [3:0]    key_code, digit_count;
  logic [VW-1:0] entry_value;

  keypad_entry_if #(.VALUE_W(VW)) bus ();

  keypad_entry #(
    .DEBOUNCE_CYCLES(DB), .RELEASE_CYCLES(REL), .MAX_DIGITS(6), .VALUE_W(VW)
  ) dut (
    .clock(clk), .resetn(rst_n), .bus(bus),
    .key_pulse(key_pulse), .key_code(key_code), .entry_value(entry_value),
    .digit_count(digit_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad face as a table: row r, column c.
  int keytab [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  // Key-level reference model.
  int run, run_row, run_col, low_run;
  bit locked;
  bit e_pulse, e_ovf, e_valid;
  int e_code, e_value, e_count, e_amount;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; low_run = 0; locked = 0;
      e_pulse = 0; e_ovf = 0; e_valid = 0;
      e_code = 0; e_value = 0; e_count = 0; e_amount = 0;
    end else begin
      bit kv;
      // The entry reacts to the strobe shown during the cycle that just ended.
      e_ovf = 0;
      if (e_valid) begin
        if (bus.amount_ready) begin
          e_valid = 0; e_value = 0; e_count = 0;
        end
      end else if (e_pulse) begin
        if (e_code < 10) begin
          if (e_count < 6) begin
            e_value = e_value * 10 + e_code;
            e_count++;
          end else begin
            e_ovf = 1;
          end
        end else if (e_code == 10) begin
          e_value = 0; e_count = 0;
        end else if (e_count > 0) begin
          e_amount = e_value; e_valid = 1;
        end
      end
      kv = bus.key_valid && bus.key_row < 4 && bus.key_col < 3;
      e_pulse = 0;
      if (!locked) begin
        if (!kv) run = 0;
        else if (run == 0) begin
          run = 1; run_row = int'(bus.key_row); run_col = int'(bus.key_col);
        end else if (int'(bus.key_row) == run_row && int'(bus.key_col) == run_col) run++;
        else run = 0;
        if (run == DB) begin
          e_pulse = 1; e_code = keytab[run_row][run_col];
          locked = 1; low_run = 0; run = 0;
        end
      end else begin
        if (kv) low_run = 0;
        else low_run++;
        if (low_run == REL) locked = 0;
      end
    end
  end

  bit cmp_en = 0;
  int n_pulse = 0;
  int n_ovf = 0;

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("cyc_key_pulse", 32'(key_pulse), 32'(e_pulse));
      check("cyc_key_code", 32'(key_code), 32'(e_code));
      check("cyc_entry_value", 32'(entry_value), 32'(e_value));
      check("cyc_digit_count", 32'(digit_count), 32'(e_count));
      check("cyc_overflow_err", 32'(overflow_err), 32'(e_ovf));
      check("cyc_amount", 32'(bus.amount), 32'(e_amount));
      check("cyc_amount_valid", 32'(bus.amount_valid), 32'(e_valid));
      check("cyc_scan_start", 32'(bus.scan_start), 32'(!locked));
    end
    if (key_pulse === 1'b1) n_pulse++;
    if (overflow_err === 1'b1) n_ovf++;
  end

  // Hold one scanner result for n sampled cycles; returns on a falling edge.
  task automatic drive(input bit v, input int row, input int col, input int n);
    bus.key_valid = v;
    bus.key_row   = 32'(row);
    bus.key_col   = 32'(col);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keytab[r][c] == code) begin
          drive(1, r, c, DB + 2);
          drive(0, 0, 0, REL + 1);
        end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_scan_start"}, 32'(bus.scan_start), 32'd1);
    check({tag, "_key_pulse"}, 32'(key_pulse), 32'd0);
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_entry_value"}, 32'(entry_value), 32'd0);
    check({tag, "_digit_count"}, 32'(digit_count), 32'd0);
    check({tag, "_overflow_err"}, 32'(overflow_err), 32'd0);
    check({tag, "_amount"}, 32'(bus.amount), 32'd0);
    check({tag, "_amount_valid"}, 32'(bus.amount_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0;
    rst_n = 1'b0;
    bus.key_valid = 1'b0; bus.key_row = '0; bus.key_col = '0; bus.amount_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    // Held key 5 gives exactly one strobe.
    p0 = n_pulse;
    drive(1, 1, 1, 10);
    drive(0, 0, 0, REL);
    check("held_pulses", 32'(n_pulse - p0), 32'd1);
    check("held_key_code", 32'(key_code), 32'd5);
    check("held_entry_value", 32'(entry_value), 32'd5);
    check("held_scan_start", 32'(bus.scan_start), 32'd1);

    // Bounce and out-of-range coordinates never reach the accept threshold.
    p0 = n_pulse;
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 2);
    drive(1, 4, 0, 6);
    drive(1, 0, 3, 6);
    drive(0, 0, 0, 3);
    check("bounce_pulses", 32'(n_pulse - p0), 32'd0);
    check("bounce_entry_value", 32'(entry_value), 32'd5);

    // Commit 120 and hold it against back-pressure and a stray key.
    press_key(10);
    press_key(1);
    press_key(2);
    press_key(0);
    press_key(11);
    check("commit_amount", 32'(bus.amount), 32'd120);
    check("commit_valid", 32'(bus.amount_valid), 32'd1);
    press_key(7);
    check("commit_amount_held", 32'(bus.amount), 32'd120);
    check("commit_key_code", 32'(key_code), 32'd7);
    check("commit_entry_frozen", 32'(entry_value), 32'd120);
    bus.amount_ready = 1'b1;
    @(negedge clk);
    bus.amount_ready = 1'b0;
    check("xfer_valid", 32'(bus.amount_valid), 32'd0);
    check("xfer_digit_count", 32'(digit_count), 32'd0);
    check("xfer_entry_value", 32'(entry_value), 32'd0);
    check("xfer_amount_kept", 32'(bus.amount), 32'd120);
    bus.amount_ready = 1'b1;
    drive(0, 0, 0, 3);
    bus.amount_ready = 1'b0;
    check("idle_ready_ignored", 32'(bus.amount_valid), 32'd0);

    // Seventh digit overflows.
    o0 = n_ovf;
    for (int i = 0; i < 7; i++) press_key(9);
    check("ovf_entry_value", 32'(entry_value), 32'd999999);
    check("ovf_digit_count", 32'(digit_count), 32'd6);
    check("ovf_pulses", 32'(n_ovf - o0), 32'd1);
    press_key(10);
    check("star_entry_value", 32'(entry_value), 32'd0);

    // '#' on an empty entry is ignored.
    press_key(11);
    check("empty_hash_valid", 32'(bus.amount_valid), 32'd0);
    press_key(3);
    check("pre_reset_entry", 32'(entry_value), 32'd3);

    // Asynchronous reset while a key is mid-debounce.
    drive(1, 1, 0, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    bus.key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press_key(8);
    check("recover_entry", 32'(entry_value), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
